// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b using one full-subtractor cell and a borrow flop
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa, sb, res, res_next;
   logic [CW-1:0]    cnt;
   logic             br, d, br_next, last;

   assign d        = sa[0] ^ sb[0] ^ br;
   assign br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign res_next = (res >> 1) | (WIDTH'(d) << (WIDTH - 1));
   assign last     = cnt == CW'(WIDTH - 1);

   // control FSM plus datapath: latch operands on start, retire one bit per edge while running
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         br     <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               br  <= br_next;
               res <= res_next;
               cnt <= cnt + 1'b1;
               if (last) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  diff   <= res_next;
                  borrow <= br_next;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= start ? RUN : IDLE;
               busy  <= start;
               if (start) begin
                  sa  <= a;
                  sb  <= b;
                  res <= '0;
                  br  <= 1'b0;
                  cnt <= '0;
               end
            end
         endcase
      end
   end
endmodule
